// File: rtl/render_cmd_sched.sv
// render_cmd_sched
//   Host-side scheduler for the sprite renderer's 48-bit command stream. Software
//   stages a command as three 16-bit Avalon writes. Commands collect in a FIFO but
//   stay hidden from the renderer until a commit appends the end-of-frame marker.
//
// Ports
//   clk50       system clock, posedge
//   reset       asynchronous, active-high reset
//   chipselect  Avalon select
//   write       Avalon write strobe
//   read        Avalon read strobe
//   address     register index: 0 stage_hi, 1 stage_mid, 2 push, 3 commit/status
//   writedata   Avalon write data
//   readdata    registered read data (status on address 3, zero otherwise)
//   cmd_dout    FIFO head, first-word-fall-through
//   cmd_valid   head belongs to a committed frame
//   cmd_pop     renderer consumes the head (ignored while cmd_valid is low)
module render_cmd_sched #(
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned CMD_W           = 48,
    parameter logic [7:0]  DO_RENDER_MAGIC = 8'hFF
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [1:0]       address,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    output logic [CMD_W-1:0] cmd_dout,
    output logic             cmd_valid,
    input  logic             cmd_pop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] One      = (AW+1)'(1);
    localparam logic [CMD_W-1:0] MarkerWord = {DO_RENDER_MAGIC, {(CMD_W-8){1'b0}}};

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count, r_committed, r_frames;
    logic             r_overflow;
    logic [15:0]      r_stage_hi, r_stage_mid, r_readdata;

    logic             w_wr, w_rd, w_push_req, w_commit_req, w_push_ok, w_commit_ok;
    logic             w_wr_en, w_ovf_set, w_status_rd, w_pop, w_pop_marker;
    logic [CMD_W-1:0] w_head, w_wr_word;
    logic [AW:0]      w_count_d, w_committed_d, w_frames_d;
    logic [7:0]       w_cnt_sat;
    logic [6:0]       w_fr_sat;
    logic [15:0]      w_status;

    assign w_wr         = chipselect & write;
    assign w_rd         = chipselect & read;
    assign w_push_req   = w_wr & (address == 2'd2);
    assign w_commit_req = w_wr & (address == 2'd3);
    // Data stops one short of full so a commit always has room for its marker.
    assign w_push_ok    = w_push_req & (r_count < (DepthCnt - One));
    assign w_commit_ok  = w_commit_req & (r_count < DepthCnt);
    assign w_wr_en      = w_push_ok | w_commit_ok;
    assign w_ovf_set    = (w_push_req & ~w_push_ok) | (w_commit_req & ~w_commit_ok);
    assign w_status_rd  = w_rd & (address == 2'd3);
    assign w_wr_word    = w_commit_ok ? MarkerWord : {r_stage_hi, r_stage_mid, writedata};

    assign w_head       = r_mem[r_rd_ptr];
    assign w_pop        = cmd_pop & (r_committed != '0);
    assign w_pop_marker = w_pop & (w_head[CMD_W-1 -: 8] == DO_RENDER_MAGIC);

    assign cmd_valid    = (r_committed != '0);
    assign cmd_dout     = cmd_valid ? w_head : '0;
    assign readdata     = r_readdata;

    always_comb begin
        w_count_d     = r_count + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_pop};
        // A commit exposes everything currently queued plus its own marker.
        w_committed_d = (w_commit_ok ? (r_count + One) : r_committed) - {{AW{1'b0}}, w_pop};
        w_frames_d    = r_frames + {{AW{1'b0}}, w_commit_ok} - {{AW{1'b0}}, w_pop_marker};

        w_cnt_sat = 8'hFF;
        if (int'(r_count) <= 255) w_cnt_sat = 8'(r_count);
        w_fr_sat = 7'h7F;
        if (int'(r_frames) <= 127) w_fr_sat = 7'(r_frames);
        // An overflow in the same cycle as the read is reported immediately.
        w_status = {r_overflow | w_ovf_set, w_fr_sat, w_cnt_sat};
    end

    always_ff @(posedge clk50) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_word;
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_committed <= '0;
            r_frames    <= '0;
            r_overflow  <= 1'b0;
            r_stage_hi  <= '0;
            r_stage_mid <= '0;
            r_readdata  <= '0;
        end else begin
            if (w_wr && address == 2'd0) r_stage_hi  <= writedata;
            if (w_wr && address == 2'd1) r_stage_mid <= writedata;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_d;
            r_committed <= w_committed_d;
            r_frames    <= w_frames_d;
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (w_status_rd) r_overflow <= 1'b0;
            if (w_rd) r_readdata <= (address == 2'd3) ? w_status : 16'h0000;
        end
    end

endmodule

// File: tb/tb_render_cmd_sched.sv
// tb_render_cmd_sched
//   Self-checking bench for render_cmd_sched (DEPTH=16): a directed vector table,
//   hand-written multi-cycle sequences, then random traffic against a queue model.
module tb_render_cmd_sched;

    localparam int D = 16;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0, cmd_pop = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [15:0] writedata = 16'h0;
    logic [15:0] readdata;
    logic [47:0] cmd_dout;
    logic        cmd_valid;

    int n_cmp = 0;
    int n_bad = 0;

    render_cmd_sched #(.DEPTH(D)) dut (
        .clk50      (clk50),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .cmd_dout   (cmd_dout),
        .cmd_valid  (cmd_valid),
        .cmd_pop    (cmd_pop)
    );

    always #10 clk50 = ~clk50;

    // Reference model: queue of entries tagged as marker or data.
    typedef struct packed {logic mark; logic [47:0] d;} ent_t;
    ent_t        mq[$];
    logic [15:0] m_hi, m_mid, m_rd;
    bit          m_ovf;

    function automatic int m_committed();
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].mark) return i + 1;
        return 0;
    endfunction

    function automatic int m_frames();
        int n = 0;
        foreach (mq[i]) if (mq[i].mark) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hi = 0; m_mid = 0; m_rd = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic cs, wr, rd, input logic [1:0] a,
                              input logic [15:0] wd, input logic pop);
        int cnt, com, fr;
        bit set;
        ent_t e;
        cnt = mq.size(); com = m_committed(); fr = m_frames();
        set = cs && wr && ((a == 2 && cnt >= D - 1) || (a == 3 && cnt >= D));
        if (cs && rd)
            m_rd = (a == 3) ? {(m_ovf || set), 7'(fr > 127 ? 127 : fr), 8'(cnt > 255 ? 255 : cnt)}
                            : 16'h0;
        if (set) m_ovf = 1;
        else if (cs && rd && a == 3) m_ovf = 0;
        if (pop && com > 0) void'(mq.pop_front());
        if (cs && wr) begin
            case (a)
                2'd0: m_hi = wd;
                2'd1: m_mid = wd;
                2'd2: if (cnt < D - 1) begin e.mark = 0; e.d = {m_hi, m_mid, wd}; mq.push_back(e); end
                default: if (cnt < D) begin e.mark = 1; e.d = 48'hFF00_0000_0000; mq.push_back(e); end
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs (set at negedge); returns 1 time unit after posedge.
    task automatic cyc(input logic cs, wr, rd, input logic [1:0] a, input logic [15:0] wd,
                       input logic pop);
        @(negedge clk50);
        chipselect = cs; write = wr; read = rd; address = a; writedata = wd; cmd_pop = pop;
        @(posedge clk50);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] wd);
        cyc(1, 1, 0, a, wd, 0);
    endtask

    task automatic rd_status(input string nm, input logic [15:0] exp);
        cyc(1, 0, 1, 2'd3, 16'h0, 0);
        chk(nm, readdata, exp);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 2'd0, 16'h0, 0);
    endtask

    task automatic do_reset();
        chipselect = 0; write = 0; read = 0; cmd_pop = 0; address = 0; writedata = 0;
        reset = 1;
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        reset = 0;
        #1;
    endtask

    typedef struct {
        logic        cs, wr, rd;
        logic [1:0]  a;
        logic [15:0] wd;
        logic        pop;
        logic        exp_valid;
        logic [47:0] exp_dout;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic [47:0] exp_list[9];
        int k, last_v;

        vt[0] = '{1, 1, 0, 2'd0, 16'h0150, 0, 0, 48'h0, 16'h0000};
        vt[1] = '{1, 1, 0, 2'd1, 16'h0064, 0, 0, 48'h0, 16'h0000};
        vt[2] = '{1, 1, 0, 2'd2, 16'h0080, 0, 0, 48'h0, 16'h0000};
        vt[3] = '{1, 0, 1, 2'd3, 16'h0000, 0, 0, 48'h0, 16'h0001};
        vt[4] = '{1, 1, 0, 2'd3, 16'h1234, 0, 1, 48'h0150_0064_0080, 16'h0001};
        vt[5] = '{0, 0, 0, 2'd0, 16'h0000, 1, 1, 48'hFF00_0000_0000, 16'h0001};
        vt[6] = '{0, 0, 0, 2'd0, 16'h0000, 1, 0, 48'h0, 16'h0001};
        vt[7] = '{1, 0, 1, 2'd3, 16'h0000, 0, 0, 48'h0, 16'h0000};

        // Reset state
        reset = 1;
        #5;
        chk("reset.valid", cmd_valid, 0);
        chk("reset.dout", cmd_dout, 0);
        chk("reset.readdata", readdata, 0);
        do_reset();

        // Directed table: single command, commit, drain
        foreach (vt[i]) begin
            cyc(vt[i].cs, vt[i].wr, vt[i].rd, vt[i].a, vt[i].wd, vt[i].pop);
            chk($sformatf("vec%0d.valid", i), cmd_valid, vt[i].exp_valid);
            chk($sformatf("vec%0d.readdata", i), readdata, vt[i].exp_rd);
            if (vt[i].exp_valid) chk($sformatf("vec%0d.dout", i), cmd_dout, vt[i].exp_dout);
        end

        // Push in the same cycle as a pop stays hidden behind the marker
        do_reset();
        wr_reg(0, 16'h0123); wr_reg(1, 16'h4567);
        wr_reg(2, 16'h0001); wr_reg(2, 16'h0002); wr_reg(3, 16'h0);
        chk("pp.valid0", cmd_valid, 1);
        chk("pp.dout0", cmd_dout, 48'h0123_4567_0001);
        cyc(1, 1, 0, 2'd2, 16'h0003, 1);
        chk("pp.dout1", cmd_dout, 48'h0123_4567_0002);
        cyc(0, 0, 0, 2'd0, 16'h0, 1);
        chk("pp.dout_marker", cmd_dout, 48'hFF00_0000_0000);
        cyc(0, 0, 0, 2'd0, 16'h0, 1);
        chk("pp.hidden", cmd_valid, 0);
        rd_status("pp.status", 16'h0001);

        // Full boundary and sticky overflow
        do_reset();
        wr_reg(0, 16'h0AAA); wr_reg(1, 16'h0BBB);
        for (int i = 0; i < D - 1; i++) wr_reg(2, 16'(i));
        chk("full.valid_uncommitted", cmd_valid, 0);
        wr_reg(2, 16'hDEAD);
        wr_reg(3, 16'h0);
        chk("full.valid_commit", cmd_valid, 1);
        wr_reg(3, 16'h0);
        rd_status("full.status_ovf", 16'h8000 | 16'h0100 | 16'(D));
        rd_status("full.status_clr", 16'h0100 | 16'(D));
        chk("full.head", cmd_dout, 48'h0AAA_0BBB_0000);

        // Continuous pop across a pointer wrap
        do_reset();
        wr_reg(0, 16'h0111); wr_reg(1, 16'h2222);
        for (int i = 0; i < 9; i++) wr_reg(2, 16'(i));
        wr_reg(3, 16'h0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 2'd0, 16'h0, 1);
        chk("wrap.drained", cmd_valid, 0);
        k = 0;
        for (int f = 0; f < 3; f++) begin
            wr_reg(0, 16'h1000 + 16'(f));
            for (int c = 0; c < 2; c++) begin
                wr_reg(2, 16'(f * 16 + c));
                exp_list[k] = {16'h1000 + 16'(f), 16'h2222, 16'(f * 16 + c)};
                k++;
            end
            wr_reg(3, 16'h0);
            exp_list[k] = 48'hFF00_0000_0000;
            k++;
        end
        k = 0;
        last_v = -1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid) begin
                if (k < 9) chk($sformatf("wrap.dout%0d", k), cmd_dout, exp_list[k]);
                k++;
                last_v = c;
            end
            cyc(0, 0, 0, 2'd0, 16'h0, 1);
        end
        chk("wrap.pops", 64'(k), 64'd9);
        chk("wrap.contiguous", 64'(last_v), 64'd8);
        rd_status("wrap.status", 16'h0000);

        // Asynchronous reset mid-stream
        do_reset();
        wr_reg(0, 16'h0C0C); wr_reg(1, 16'h0D0D);
        for (int i = 0; i < 4; i++) wr_reg(2, 16'(i));
        wr_reg(3, 16'h0);
        rd_status("areset.pre_status", 16'h0105);
        idle();
        @(negedge clk50);
        #3 reset = 1;
        #1;
        chk("areset.valid", cmd_valid, 0);
        chk("areset.readdata", readdata, 0);
        chk("areset.dout", cmd_dout, 0);
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        reset = 0;
        #1;
        wr_reg(2, 16'h0077);
        wr_reg(3, 16'h0);
        chk("areset.new_valid", cmd_valid, 1);
        chk("areset.new_dout", cmd_dout, 48'h0000_0000_0077);
        cyc(0, 0, 0, 2'd0, 16'h0, 1);
        chk("areset.marker", cmd_dout, 48'hFF00_0000_0000);
        cyc(0, 0, 0, 2'd0, 16'h0, 1);
        chk("areset.empty", cmd_valid, 0);

        // Random traffic against the queue model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic cs, wr, rd, pop;
            logic [1:0] a;
            logic [15:0] wd;
            int r, sel, pop_pct;
            pop_pct = ((i / 400) % 2 != 0) ? 15 : 70;
            r = $urandom_range(0, 99);
            cs = 1; wr = 0; rd = 0;
            wd = 16'($urandom);
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd1 : (sel < 8) ? 2'd2 : 2'd3;
            if (r < 12) begin
                rd = 1;
                a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
            end else if (r < 15) begin
                rd = 1; wr = 1;
            end else if (r < 60) begin
                wr = 1;
            end else begin
                cs = 1'($urandom_range(0, 1));
            end
            if (a == 2'd0) wd[15] = 1'b0;  // keep data magic distinct from the marker
            pop = ($urandom_range(0, 99) < pop_pct);
            model_step(cs, wr, rd, a, wd, pop);
            cyc(cs, wr, rd, a, wd, pop);
            chk($sformatf("rnd%0d.valid", i), cmd_valid, (m_committed() > 0));
            chk($sformatf("rnd%0d.readdata", i), readdata, m_rd);
            if (m_committed() > 0) chk($sformatf("rnd%0d.dout", i), cmd_dout, mq[0].d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/render_cmd_sched.md
Name: render_cmd_sched

Overview:
- Host-facing scheduler for the sprite renderer's 48-bit instruction stream.
- Software writes sprite commands as three 16-bit Avalon words; they collect in an on-chip FIFO and are hidden from the renderer until software commits the frame.
- A commit appends the DO_RENDER marker; only committed commands are presented to the renderer through a valid/pop handshake.
- Sits between the Avalon slave bus and the renderer's render_queue_dout / render_queue_pop_front interface.

Parameters:
- DEPTH, 64: FIFO entries, power of two, 4..256.
- CMD_W, 48: command width; fixed layout {magic[47:40], x[39:24], y[23:8], flags[7:0]}.
- DO_RENDER_MAGIC, 8'hFF: magic byte of the end-of-frame marker.

Ports:
- clk50  in  1  system clock; all logic on posedge.
- reset  in  1  reset, asynchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  2  register index.
- writedata  in  16  Avalon write data.
- readdata  out  16  Avalon read data, registered.
- cmd_dout  out  48  FIFO head command.
- cmd_valid  out  1  head is a committed command.
- cmd_pop  in  1  renderer consumes head; one pulse per command.

Behaviour:
- Register map, writes:
  - addr0: stage_hi <= writedata (cmd[47:32]).
  - addr1: stage_mid <= writedata (cmd[31:16]).
  - addr2: push {stage_hi, stage_mid, writedata} into the FIFO. Staging registers are unchanged by the push.
  - addr3: commit, writedata ignored. Pushes {DO_RENDER_MAGIC, 40'h0}.
- Register map, reads:
  - addr3 returns status: [15] overflow; [14:8] frames_pending, saturating at 127; [7:0] count, saturating at 255.
  - addr0-2 return 16'h0.
  - readdata is registered: valid the cycle after the read strobe, held until the next read.
- Accept rules:
  - Data push (addr2) is accepted only when count < DEPTH-1, which leaves one slot for the marker.
  - Commit is accepted only when count < DEPTH.
  - A rejected push or commit leaves the FIFO unchanged and sets overflow.
- Counters:
  - count: total entries.
  - committed: entries up to and including the newest marker.
  - frames_pending: markers currently in the FIFO.
  - Accepted commit: committed <= count + 1 (plus the usual pop adjustment); frames_pending += 1.
  - Accepted data push: changes count only.
- Handshake:
  - cmd_valid = (committed != 0).
  - cmd_dout = mem[rd_ptr], first-word-fall-through. It must equal the head whenever cmd_valid=1, and is don't-care otherwise.
  - A pop is effective only when cmd_pop=1 and cmd_valid=1. It advances rd_ptr and decrements count and committed.
  - If the popped entry's magic == DO_RENDER_MAGIC, frames_pending decrements.
  - cmd_pop while cmd_valid=0 is ignored and is not an error.
  - After an effective pop, the next head appears on cmd_dout at the same clock edge. Back-to-back pops every cycle are supported.
- Latency: commit write at edge N gives cmd_valid=1 after edge N, provided the FIFO was previously uncommitted-empty.
- Simultaneous events in the same cycle:
  - Push + pop: count unchanged; full check uses pre-pop count (conservative).
  - Commit + pop: committed = count + 1 − 1 over both terms; frames_pending nets correctly (+1 and −1 when a marker is popped).
  - Status read + overflow event: set wins; overflow reads 1 now and next read.
- Overflow: sticky. Cleared by an accepted status read (chipselect & read & address==3) unless set in the same cycle.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (async, any time including mid-frame):
  - Clear pointers, count, committed, frames_pending, overflow, stage_hi, stage_mid.
  - Outputs: readdata=0, cmd_valid=0, cmd_dout=0.
  - Uncommitted and committed entries are discarded; FIFO storage contents need not be cleared.

Test Plan:
- Reset, write addr0=16'h0150, addr1=16'h0064, addr2=16'h0080, no commit → cmd_valid stays 0; status read = 16'h0001.
- Same, then commit → next cycle cmd_valid=1, cmd_dout=48'h0150_0064_0080. Pop → head is 48'hFF00_0000_0000. Pop → cmd_valid=0. Status = 16'h0000.
- Two commands then commit; while the renderer pops the first, write a third command in the same cycle → third stays hidden after marker popped; status reports count=1, frames_pending=0.
- Fill DEPTH-1 data pushes, push once more → rejected, overflow=1. Commit accepted, count=DEPTH. Next commit rejected. Status read returns 0x8000|(1<<8)|(DEPTH saturated); following read shows overflow=0.
- Continuous cmd_pop=1 with 3 committed frames of 2 commands each → exactly 9 effective pops in 9 consecutive cycles, in write order, with pointers wrapping past DEPTH after prefill; cmd_pop with cmd_valid=0 changes nothing.
- Assert reset mid-stream with 5 committed entries → cmd_valid=0 and readdata=0 immediately (async). After release, a new 1-command frame is delivered correctly.
